// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: DDS frequency controller for the 50 MHz system domain.
// Up/down keys step the frequency code. Codes up to F_FINE_MAX step by 1,
// codes above that step by F_COARSE_STEP, and both directions saturate.
// Raising learn_en saves the user code and starts a sweep from LEARN_START.
// The sweep steps on next_freq rising edges, or on the auto-dwell timer when
// AUTO_DWELL is non-zero. Lowering learn_en restores the saved code.
// Ports:
//   clk_50m, rst_n    system clock, async active-low reset
//   key_dn_n_i        down key, active-low debounced level
//   key_up_n_i        up key, active-low debounced level
//   learn_en_i        learn sweep enable (level)
//   next_freq_i       manual sweep step (rising edge)
//   freq_o            current frequency code (Hz/100)
//   pinc_o            DDS phase-increment word (quasi-static into DDS domain)
//   freq_valid_o      one-cycle pulse when pinc_o changes
//   sweep_busy_o      high while sweeping or holding at the top
//   sweep_done_o      high while holding at the top of the sweep
module freq_sweep_ctrl #(
    parameter int unsigned FREQ_W        = 16,
    parameter int unsigned PINC_W        = 24,
    parameter int unsigned PINC_MUL      = 10,
    parameter int unsigned F_MIN         = 1,
    parameter int unsigned F_FINE_MAX    = 30,
    parameter int unsigned F_COARSE_STEP = 15000,
    parameter int unsigned F_MAX         = 45000,
    parameter int unsigned LEARN_START   = 10,
    parameter int unsigned LEARN_STEP    = 2,
    parameter int unsigned AUTO_DWELL    = 0,
    parameter int unsigned DWELL_W       = 26
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              key_dn_n_i,
    input  logic              key_up_n_i,
    input  logic              learn_en_i,
    input  logic              next_freq_i,
    output logic [FREQ_W-1:0] freq_o,
    output logic [PINC_W-1:0] pinc_o,
    output logic              freq_valid_o,
    output logic              sweep_busy_o,
    output logic              sweep_done_o
);

    localparam int unsigned FW1    = FREQ_W + 1;
    localparam int unsigned CALC_W = FREQ_W + 5;

    localparam logic [FREQ_W-1:0] FMIN_C   = FREQ_W'(F_MIN);
    localparam logic [FREQ_W-1:0] FFINE_C  = FREQ_W'(F_FINE_MAX);
    localparam logic [FREQ_W-1:0] FCOARSE_C = FREQ_W'(F_COARSE_STEP);
    localparam logic [FREQ_W-1:0] FMAX_C   = FREQ_W'(F_MAX);
    localparam logic [FREQ_W-1:0] LSTART_C = FREQ_W'(LEARN_START);
    localparam logic [PINC_W-1:0] PINC_RST = PINC_W'(F_MIN * PINC_MUL + ((F_MIN + 2) >> 2));
    // Bit order {next, learn, up, dn}; keys idle high.
    localparam logic [3:0]        SYNC_RST = 4'b0011;

    typedef enum logic [1:0] {
        ST_NORM,
        ST_SWEEP,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [FREQ_W-1:0]   save_q, save_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [PINC_W-1:0]   pinc_q;
    logic                valid_q, busy_q, done_q;
    logic [3:0]          sync0_q, sync1_q, sync2_q;

    logic                dn_press_c, up_press_c, learn_rise_c, learn_fall_c, next_rise_c;
    logic                auto_c, step_c, in_fine_c, in_coarse_c;
    logic [FW1-1:0]      coarse_sum_c, sweep_sum_c;
    logic [CALC_W-1:0]   calc_c;
    logic [PINC_W-1:0]   pinc_c;

    // Two-flop synchronisers plus one edge-detect stage
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= SYNC_RST;
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync0_q <= {next_freq_i, learn_en_i, key_up_n_i, key_dn_n_i};
            sync1_q <= sync0_q;
            sync2_q <= sync1_q;
        end
    end

    assign dn_press_c   = sync2_q[0] & ~sync1_q[0];
    assign up_press_c   = sync2_q[1] & ~sync1_q[1];
    assign learn_rise_c = sync1_q[2] & ~sync2_q[2];
    assign learn_fall_c = ~sync1_q[2] & sync2_q[2];
    assign next_rise_c  = sync1_q[3] & ~sync2_q[3];

    // Auto step fires on the last dwell cycle; absent when AUTO_DWELL is 0
    generate
        if (AUTO_DWELL != 0) begin : g_auto
            assign auto_c = (dwell_q == DWELL_W'(AUTO_DWELL - 1));
        end else begin : g_manual
            assign auto_c = 1'b0;
        end
    endgenerate

    assign step_c       = next_rise_c | auto_c;
    assign in_fine_c    = (freq_q >= FMIN_C) && (freq_q <= FFINE_C);
    assign in_coarse_c  = (freq_q >= FCOARSE_C) && (freq_q <= FMAX_C);
    assign coarse_sum_c = {1'b0, freq_q} + FW1'(F_COARSE_STEP);
    assign sweep_sum_c  = {1'b0, freq_q} + FW1'(LEARN_STEP);

    // Next-state and frequency update
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        save_d  = save_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_NORM: begin
                if (learn_rise_c) begin
                    save_d  = freq_q;
                    freq_d  = LSTART_C;
                    dwell_d = '0;
                    state_d = ST_SWEEP;
                end else if (up_press_c && !dn_press_c) begin
                    if (in_fine_c) begin
                        freq_d = (freq_q < FFINE_C) ? freq_q + FREQ_W'(1) : FCOARSE_C;
                    end else if (in_coarse_c) begin
                        freq_d = (coarse_sum_c > FW1'(F_MAX)) ? FMAX_C : coarse_sum_c[FREQ_W-1:0];
                    end else begin
                        freq_d = FCOARSE_C;
                    end
                end else if (dn_press_c && !up_press_c) begin
                    if (in_coarse_c) begin
                        freq_d = (freq_q > FCOARSE_C) ? freq_q - FCOARSE_C : FFINE_C;
                    end else if (in_fine_c) begin
                        freq_d = (freq_q > FMIN_C) ? freq_q - FREQ_W'(1) : freq_q;
                    end else begin
                        freq_d = FFINE_C;
                    end
                end
            end
            ST_SWEEP: begin
                // Exit wins over a step in the same cycle
                if (learn_fall_c) begin
                    freq_d  = save_q;
                    dwell_d = '0;
                    state_d = ST_NORM;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                    if (step_c) begin
                        dwell_d = '0;
                        if (sweep_sum_c > FW1'(F_MAX)) begin
                            state_d = ST_HOLD;
                        end else begin
                            freq_d = sweep_sum_c[FREQ_W-1:0];
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (learn_fall_c) begin
                    freq_d  = save_q;
                    dwell_d = '0;
                    state_d = ST_NORM;
                end
            end
            default: begin
                state_d = ST_NORM;
            end
        endcase
    end

    // pinc = f*PINC_MUL + round(f/4), saturated to the output width
    assign calc_c = CALC_W'(freq_q) * CALC_W'(PINC_MUL)
                  + ((CALC_W'(freq_q) + CALC_W'(2)) >> 2);

    generate
        if (CALC_W > PINC_W) begin : g_sat
            assign pinc_c = (|calc_c[CALC_W-1:PINC_W]) ? '1 : calc_c[PINC_W-1:0];
        end else begin : g_nosat
            assign pinc_c = PINC_W'(calc_c);
        end
    endgenerate

    // State, frequency and registered outputs
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORM;
            freq_q  <= FMIN_C;
            save_q  <= FMIN_C;
            dwell_q <= '0;
            pinc_q  <= PINC_RST;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            save_q  <= save_d;
            dwell_q <= dwell_d;
            pinc_q  <= pinc_c;
            valid_q <= (pinc_c != pinc_q);
            busy_q  <= (state_d != ST_NORM);
            done_q  <= (state_d == ST_HOLD);
        end
    end

    assign freq_o       = freq_q;
    assign pinc_o       = pinc_q;
    assign freq_valid_o = valid_q;
    assign sweep_busy_o = busy_q;
    assign sweep_done_o = done_q;

endmodule
